dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder for the pipelined core: target end of the load/store request interface driven by the memory stage.
// - Accepts one request at a time over a valid/ready handshake and returns a response after WAIT_STATES cycles.
// - Performs RV32 byte/half/word store merging and load sign/zero extension.
// - Word-addressed internal array; acknowledges both loads and stores.
// PARAMETERS
// - DATA_WIDTH     32  data width; only 32 supported
// - ADDRESS_WIDTH  32  byte address width
// - DEPTH_LOG2     10  log2 of array depth in words (default 1024 words)
// - WAIT_STATES    1   extra cycles between accept and response, 0..15
// PORTS
// - clk         in   1              clock, rising edge
// - rst         in   1              synchronous active-low reset
// - req_valid   in   1              request present
// - req_ready   out  1              responder can accept
// - req_we      in   1              1=store, 0=load
// - req_funct3  in   3              RV32 funct3 size/sign code
// - req_addr    in   ADDRESS_WIDTH  byte address
// - req_wdata   in   DATA_WIDTH     store data, right-aligned
// - resp_valid  out  1              response present
// - resp_ready  in   1              requester takes response
// - resp_rdata  out  DATA_WIDTH     load data, extended; 0 for stores
// - resp_err    out  1              access error (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=0 at clk edge): state=IDLE, wait counter=0, req_ready=0 that cycle, resp_valid=0, resp_rdata=0, resp_err=0.
// - Reset does not clear the array. Reset mid-operation aborts the request. A store not yet committed is dropped.
// - FSM IDLE: req_ready=1. On req_valid&&req_ready, latch we/funct3/addr/wdata.
//   Then go to WAIT if WAIT_STATES>0, otherwise go to RESP.
// - FSM WAIT: counter counts up to WAIT_STATES-1. On the last count, go to RESP. req_ready=0.
// - Entering RESP: commit the store to the array, or capture the load data. Then resp_valid=1.
// - resp_valid, resp_rdata and resp_err stay stable until resp_ready=1. Then go to IDLE and clear resp_valid.
// - Latency: request accepted at edge N gives resp_valid=1 after edge N+1+WAIT_STATES.
//   The next accept is no earlier than one cycle after the response handshake.
// - Index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
// - Loads: funct3 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU.
//   Lane select uses addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
// - Stores: funct3 000=SB, 001=SH, 010=SW. Only the addressed byte lanes change; the other lanes keep their value.
// - Simultaneous resp handshake and new req_valid: the new request is not accepted that cycle (req_ready=0).
// CONFIGURATION
// - Macro DMEM_ALIGN_CHECK_EN.
// - Defined:
//   - Error cases: half access with addr[0]=1, word access with addr[1:0]!=0, or funct3 in {011,110,111}. Stores also error on funct3 1xx.
//   - On error: resp_err=1, no array write, resp_rdata=0. Response timing is unchanged.
// - Undefined:
//   - resp_err is tied to 0.
//   - Half access forces addr[0]=0; word access forces addr[1:0]=0.
//   - Any other funct3 is treated as LW/SW.
// TESTING
// - Reset with WAIT_STATES=1: resp_valid=0, resp_err=0; req_ready=1 one cycle after rst=1.
// - SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF. resp_valid rises 2 cycles after accept.
// - SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW -> 0x80000000.
// - SH 0x1234 @0x22 over 0xAAAAAAAA, then LW @0x20 -> 0x1234AAAA. LH @0x22 with word 0x8001xxxx -> 0xFFFF8001.
// - Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready=0.
//   Release -> req_ready=1 the next cycle.
// - DMEM_ALIGN_CHECK_EN defined: SW @0x21 -> resp_err=1 and word @0x20 unchanged. Undefined: SW @0x21 writes word @0x20.
// - Wrap: SW 0x5 @(4<<DEPTH_LOG2), then LW @0x0 -> 0x5.
// - Reset asserted in WAIT during an SW -> target word keeps its prior value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's load/store request port.
// Accepts one request at a time, waits WAIT_STATES cycles, then commits the
// store (byte-lane merge) or captures the load (sign/zero extended).
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, misaligned
// or illegal accesses raise resp_err. When it is undefined, resp_err is 0 and
// the address is forced to the natural alignment of the access.
// Only DATA_WIDTH=32 is supported.
module dmem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_LOG2    = 10,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Final value of the wait counter; unused when WAIT_STATES is 0.
  localparam logic [3:0] LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Access size codes produced by size_of().
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // S_ACCESS is the single cycle in which the array is read or written;
  // S_RESP holds the registered response until the requester takes it.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_init;

  logic                    r_we;
  logic [2:0]              r_f3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_accept;
  logic                    w_cnt_last;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [1:0]              w_size;
  logic [1:0]              w_lane;
  logic                    w_unsigned;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wword;
  logic [DATA_WIDTH-1:0]   w_load;
  logic                    w_err;
  logic                    w_commit;
  logic                    w_unused_addr;

  // Size decode. Encodings outside the RV32 set fall back to a word access.
  function automatic logic [1:0] size_of(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (we) begin
      case (f3)
        3'b000:  sz = SZ_BYTE;
        3'b001:  sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: sz = SZ_BYTE;
        3'b001, 3'b101: sz = SZ_HALF;
        default:        sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] lanes_of(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane it may land in.
  function automatic logic [31:0] store_word(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{wd[7:0]}};
      SZ_HALF: w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  // Pick the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] a, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {a, 3'b000};
    case (sz)
      SZ_BYTE: res = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

`ifdef DMEM_ALIGN_CHECK_EN
  // Illegal encodings and misaligned half/word accesses.
  function automatic logic err_of(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic illegal;
    logic mis;
    logic [1:0] sz;
    sz      = size_of(we, f3);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    mis     = ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
    return illegal || mis;
  endfunction
`endif

  assign w_accept      = req_valid && req_ready;
  assign w_cnt_last    = (r_cnt == LAST_CNT);
  assign w_idx         = r_addr[DEPTH_LOG2+1:2];
  assign w_size        = size_of(r_we, r_f3);
  assign w_unsigned    = !r_we && r_f3[2];
  // Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  assign w_lane        = (w_size == SZ_BYTE) ? r_addr[1:0] :
                         (w_size == SZ_HALF) ? {r_addr[1], 1'b0} : 2'b00;
  assign w_be          = lanes_of(w_size, w_lane);
  assign w_wword       = store_word(w_size, r_wdata);
  assign w_load        = load_extract(r_mem[w_idx], w_size, w_lane, w_unsigned);
  assign w_commit      = (r_state == S_ACCESS) && r_we && !w_err;
  // Upper address bits alias onto the array; only fold them here.
  assign w_unused_addr = ^r_addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;

  assign w_err    = err_of(r_we, r_f3, r_addr[1:0]);
  assign resp_err = r_err;

  // Error flag is captured with the response and held until the handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_err <= w_err;
    end
  end
`else
  assign w_err    = 1'b0;
  assign resp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Holds req_ready low in the cycle reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_init <= 1'b0;
    end else begin
      r_init <= 1'b1;
    end
  end

  // Wait-state counter runs only while in S_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if ((r_state == S_WAIT) && !w_cnt_last) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  // Latch the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_f3    <= req_funct3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Capture load data in S_ACCESS; stores and errors return zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (r_state == S_ACCESS) begin
      r_rdata <= (r_we || w_err) ? '0 : w_load;
    end
  end

  // Byte-lane store commit; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (w_cnt_last) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    req_ready  = (r_state == S_IDLE) && r_init;
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_STATES=1, DEPTH_LOG2=10).
// Expected responses are queued at issue; a monitor compares on handshake.
module tb_dmem_responder;

  localparam int WS = 1;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  string       name_q[$];

  dmem_responder #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_LOG2(DL), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=0x%08h required=none", resp_rdata);
      end else begin
        logic [32:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, "_rdata"}, resp_rdata, e[31:0]);
        chk({n, "_err"}, {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int stall, input string name);
    int n;
    logic [31:0] held;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (stall > 0) resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    exp_q.push_back({exp_err, exp_rd});
    name_q.push_back(name);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, WS + 1);
    if (!resp_valid) return;
    if (stall > 0) begin
      held = resp_rdata;
      repeat (stall) begin
        @(negedge clk);
        chk({name, "_stall_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_stall_rdata"}, resp_rdata, held);
        chk({name, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    if (stall > 0) begin
      @(negedge clk);
      chk({name, "_ready_after_release"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1 chk("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Word store / load
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw_10");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_10");

    // Byte store merge and byte loads
    do_req(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 0, "sw_10_zero");
    do_req(1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0, 0, "sb_13");
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0, "lb_13");
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 0, "lbu_13");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0, 0, "lw_10_b");

    // Half store merge and half/byte loads
    do_req(1'b1, 3'b010, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0, 0, "sw_20");
    do_req(1'b1, 3'b001, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, 0, "sh_22");
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234AAAA, 1'b0, 0, "lw_20");
    do_req(1'b1, 3'b010, 32'h20, 32'h80015555, 32'h0, 1'b0, 0, "sw_20_b");
    do_req(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 0, "lh_22");
    do_req(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 0, "lhu_22");
    do_req(1'b0, 3'b001, 32'h20, 32'h0, 32'h00005555, 1'b0, 0, "lh_20");
    do_req(1'b0, 3'b000, 32'h21, 32'h0, 32'h00000055, 1'b0, 0, "lb_21");
    do_req(1'b0, 3'b100, 32'h22, 32'h0, 32'h00000001, 1'b0, 0, "lbu_22");
    do_req(1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 0, "lb_23");

    // Back-pressure on the response
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0, 5, "lw_stall");

`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b1, 3'b010, 32'h21, 32'hCAFEF00D, 32'h0, 1'b1, 0, "sw_21_err");
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80015555, 1'b0, 0, "lw_20_kept");
    do_req(1'b0, 3'b001, 32'h23, 32'h0, 32'h0, 1'b1, 0, "lh_23_err");
    do_req(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 0, "ld_f3_011_err");
    do_req(1'b0, 3'b111, 32'h20, 32'h0, 32'h0, 1'b1, 0, "ld_f3_111_err");
    do_req(1'b1, 3'b100, 32'h20, 32'h01020304, 32'h0, 1'b1, 0, "st_f3_100_err");
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80015555, 1'b0, 0, "lw_20_kept2");
`else
    do_req(1'b1, 3'b010, 32'h21, 32'hCAFEF00D, 32'h0, 1'b0, 0, "sw_21_forced");
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0, "lw_20_forced");
    do_req(1'b0, 3'b001, 32'h23, 32'h0, 32'hFFFFCAFE, 1'b0, 0, "lh_23_forced");
    do_req(1'b0, 3'b011, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0, "ld_f3_011_lw");
    do_req(1'b0, 3'b111, 32'h22, 32'h0, 32'hCAFEF00D, 1'b0, 0, "ld_f3_111_lw");
    do_req(1'b1, 3'b100, 32'h20, 32'h01020304, 32'h0, 1'b0, 0, "st_f3_100_sw");
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h01020304, 1'b0, 0, "lw_20_sw");
`endif

    // Address wrap
    do_req(1'b1, 3'b010, 32'(4 << DL), 32'h5, 32'h0, 1'b0, 0, "sw_wrap");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h5, 1'b0, 0, "lw_wrap");

    // Reset while a store waits
    do_req(1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 1'b0, 0, "sw_30");
    @(negedge clk);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    req_wdata  = 32'h22222222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 32'h11111111, 1'b0, 0, "lw_30_kept");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
